adder_operand_sequencer: RTL
============================

// Module: adder_operand_sequencer
// PURPOSE
//  Sequencer around the team's combinational 8-bit adder (a, b, cin -> sum, cout).
//  - Upstream: loads operand A, then B+cin, from one shared byte bus.
//  - Downstream: registers {cout,sum}, presents it on a valid/ready result port.
//  - Lets a single input bus/switch bank drive the adder, with result held for display or consumer.
// PARAMETERS
//  WIDTH         8    operand width; result is WIDTH+1 bits
//  LOAD_TIMEOUT  255  max idle cycles in WAIT_B before abort (must be >= 1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  din        in   WIDTH    operand byte bus
//  din_valid  in   1        din qualifier
//  din_ready  out  1        1 in IDLE/WAIT_B; transfer = din_valid & din_ready
//  cin_in     in   1        carry-in, sampled with operand B
//  op_a       out  WIDTH    to adder a (registered)
//  op_b       out  WIDTH    to adder b (registered)
//  op_cin     out  1        to adder cin (registered)
//  add_sum    in   WIDTH    from adder sum
//  add_cout   in   1        from adder cout
//  result     out  WIDTH+1  {cout,sum} captured in EXEC
//  res_valid  out  1        result valid, held until accepted
//  res_ready  in   1        consumer accept
//  busy       out  1        1 in WAIT_B, EXEC, DONE
//  err        out  1        1-cycle pulse on load timeout
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; op_a/op_b/op_cin/result/res_valid/err/cnt=0. Mid-operation reset aborts instantly, no result.
//  - IDLE:   on din transfer -> op_a<=din, cnt<=0, go WAIT_B.
//  - WAIT_B: on din transfer -> op_b<=din, op_cin<=cin_in, go EXEC.
//      Else cnt++; if cnt==LOAD_TIMEOUT-1 -> err=1 one cycle, op_a<=0, go IDLE.
//      din_valid beats timeout in the same cycle.
//  - EXEC (1 cycle): result<={add_cout,add_sum} (adder combinational, settles from registered ops), go DONE.
//  - DONE:   res_valid=1; result/op_* stable.
//      On res_ready -> res_valid<=0, go IDLE.
//      din_ready=0 in EXEC/DONE: din offered there is not consumed and stays pending at the source.
//  - Latency: B transfer at edge t -> res_valid=1 after edge t+2. With res_ready held 1: next A accepted one cycle after accept.
//  - Arithmetic: full WIDTH+1 sum, no truncation. 0xFF+0xFF+1 = 0x1FF.
//  - All outputs registered except din_ready/busy (decoded from state).
// CONFIGURATION
//  SIGNED_OVF_EN defined:
//    - Adds out port ovf (1): two's-complement overflow = (op_a[MSB]==op_b[MSB]) & (add_sum[MSB]!=op_a[MSB]).
//    - Captured in EXEC alongside result; cleared on reset and on DONE->IDLE.
//  Undefined: port and logic absent; unsigned behaviour identical.
// STRUCTURE
//  - Shared include adder_seq_defs.vh: state encodings (IDLE=2'd0, WAIT_B=2'd1, EXEC=2'd2, DONE=2'd3), default WIDTH/LOAD_TIMEOUT.
//  - One sub-module: load_timeout_cnt (clear/enable/terminal-count, width $clog2(LOAD_TIMEOUT+1)).
//  - Top holds FSM + operand/result regs; adder instantiated by parent, not inside this block.
// TESTING (bench models adder combinationally)
//  - A=0x3C, B=0xA5, cin=0, res_ready=1 -> result=0x0E1, res_valid one cycle, exactly 2 cycles after B.
//  - A=0xFF, B=0x01, cin=1 -> result=0x101; A=0xFF, B=0xFF, cin=1 -> 0x1FF.
//  - A only, din_valid low 255 cycles -> err 1-cycle pulse, back to IDLE, op_a=0; din at cycle 254 instead -> accepted, no err.
//  - res_ready=0 for 10 cycles in DONE, din_valid=1 -> result stable, din_ready=0, din not consumed; release -> IDLE, A accepted next cycle.
//  - rst_n low during WAIT_B and during DONE -> all outputs 0 immediately, IDLE after release.
//  - SIGNED_OVF_EN: 0x7F+0x01 -> ovf=1, result=0x080; 0x80+0x80 -> ovf=1, result=0x100; 0x10+0x20 -> ovf=0.

Source files
------------

// File: rtl/adder_operand_sequencer_pkg.sv
// Shared definitions for the adder operand sequencer: FSM state encodings
// and the default operand width / load timeout used by the top level.
package adder_operand_sequencer_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_LOAD_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  // Counter width able to hold every value from 0 up to the timeout itself.
  function automatic int unsigned timeout_cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/adder_operand_sequencer_load_timeout_cnt.sv
// Idle-cycle counter for the operand-B wait: synchronous clear, count enable,
// and a terminal-count flag raised when the count reaches LOAD_TIMEOUT-1.
module load_timeout_cnt
  import adder_operand_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = DEF_LOAD_TIMEOUT,
  parameter int unsigned CW           = timeout_cnt_width(LOAD_TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(LOAD_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/adder_operand_sequencer.sv
// Loads operand A then B+cin from one byte bus, drives an external combinational
// adder and holds {cout,sum} on a valid/ready port. SIGNED_OVF_EN adds an ovf output.
module adder_operand_sequencer
  import adder_operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             cin_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH:0]   result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned MSB = WIDTH - 1;

  seq_state_e       r_state;
  seq_state_e       w_nextState;
  logic             w_xfer;
  logic             w_loadA;
  logic             w_loadB;
  logic             w_timeout;
  logic             w_capture;
  logic             w_accept;
  logic             w_cntClr;
  logic             w_cntEn;
  logic             w_tc;

  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_opCin;
  logic [WIDTH:0]   r_result;
  logic             r_resValid;
  logic             r_err;

  assign din_ready = (r_state == ST_IDLE) || (r_state == ST_WAIT_B);
  assign busy      = (r_state != ST_IDLE);
  assign w_xfer    = din_valid & din_ready;

  load_timeout_cnt #(
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) u_load_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cntClr),
    .i_en  (w_cntEn),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A valid B beat in WAIT_B always wins over the timeout in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_timeout   = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_cntClr    = 1'b0;
    w_cntEn     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_loadA     = 1'b1;
          w_cntClr    = 1'b1;
          w_nextState = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (w_xfer) begin
          w_loadB     = 1'b1;
          w_nextState = ST_EXEC;
        end else if (w_tc) begin
          w_timeout   = 1'b1;
          w_nextState = ST_IDLE;
        end else begin
          w_cntEn     = 1'b1;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_nextState = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          w_accept    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA      <= '0;
      r_opB      <= '0;
      r_opCin    <= 1'b0;
      r_result   <= '0;
      r_resValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_loadA) begin
        r_opA <= din;
      end else if (w_timeout) begin
        r_opA <= '0;
      end
      if (w_loadB) begin
        r_opB   <= din;
        r_opCin <= cin_in;
      end
      if (w_capture) begin
        r_result   <= {add_cout, add_sum};
        r_resValid <= 1'b1;
      end else if (w_accept) begin
        r_resValid <= 1'b0;
      end
    end
  end

  assign op_a      = r_opA;
  assign op_b      = r_opB;
  assign op_cin    = r_opCin;
  assign result    = r_result;
  assign res_valid = r_resValid;
  assign err       = r_err;

`ifdef SIGNED_OVF_EN
  logic r_ovf;

  // Same-sign operands producing an opposite-sign sum is a two's-complement overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_ovf <= (r_opA[MSB] == r_opB[MSB]) & (add_sum[MSB] != r_opA[MSB]);
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
